freq_hop_sched: RTL and testbench

- Sequencer that drives the phase-increment interface of the frequency-offset datapath in the channel emulator.
- Holds a small programmable table of (phase increment, dwell) entries and steps through it, dwelling on each entry for a programmed number of accepted samples.
- Before each run it pulses a reset to the datapath so its phase accumulator and CORDIC restart from a known state.
- When idle, it presents phase 0 with valid high, which puts the datapath into passthrough.

---
 rtl/freq_hop_pkg.sv | 25 ++
 rtl/freq_hop_table.sv | 48 ++++
 rtl/freq_hop_sched.sv | 204 ++++++++++++++++++++
 tb/tb_freq_hop_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_hop_pkg.sv
// freq_hop_pkg
//   Shared types and constants for the frequency-hop scheduler slice.
//   - state_e    : scheduler FSM states (IDLE, CLR, RUN)
//   - PHASE_W    : width of the datapath phase-increment word
//   - IDLE_PHASE : phase presented while idle (puts the datapath in passthrough)
//   - idx_width(): table index width derived from the table depth
package freq_hop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int PHASE_W = 16;
  localparam logic [PHASE_W-1:0] IDLE_PHASE = 16'h0000;

  localparam int DEFAULT_DEPTH = 8;

  // A depth of 1 would give a zero-width index, so clamp to one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/freq_hop_table.sv
// freq_hop_table
//   Register file holding the (phase increment, dwell) hop entries.
//   Ports:
//     clk, areset_n        : clock, async active-low reset (clears every entry)
//     we_i, waddr_i        : write strobe and index (gating is done by the caller)
//     wphase_i, wdwell_i   : data written into the addressed entry
//     cur_idx_i/cur_phase_o: combinational read of the active entry's phase
//     nxt_idx_i/nxt_phase_o/nxt_dwell_o : combinational read of the entry about to load
module freq_hop_table
  import freq_hop_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int DWELL_W = 32,
  localparam int IDX_W  = idx_width(DEPTH)
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [PHASE_W-1:0] wphase_i,
  input  logic [DWELL_W-1:0] wdwell_i,
  input  logic [IDX_W-1:0]   cur_idx_i,
  output logic [PHASE_W-1:0] cur_phase_o,
  input  logic [IDX_W-1:0]   nxt_idx_i,
  output logic [PHASE_W-1:0] nxt_phase_o,
  output logic [DWELL_W-1:0] nxt_dwell_o
);

  logic [PHASE_W-1:0] phase_q [DEPTH];
  logic [DWELL_W-1:0] dwell_q [DEPTH];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        phase_q[i] <= '0;
        dwell_q[i] <= '0;
      end
    end else if (we_i) begin
      phase_q[waddr_i] <= wphase_i;
      dwell_q[waddr_i] <= wdwell_i;
    end
  end

  assign cur_phase_o = phase_q[cur_idx_i];
  assign nxt_phase_o = phase_q[nxt_idx_i];
  assign nxt_dwell_o = dwell_q[nxt_idx_i];

endmodule

// File: rtl/freq_hop_sched.sv
// freq_hop_sched
//   Steps the frequency-offset datapath through a programmable table of
//   (phase increment, dwell) entries. Each run starts with a CLR_CYCLES-long
//   reset pulse to the datapath, then presents each entry's phase for its
//   dwell, counted in accepted samples (tick). While idle the datapath sees
//   phase 0 with valid high, i.e. passthrough.
//   Ports:
//     clk, areset_n              : clock, async active-low reset
//     cfg_we/addr/phase/dwell    : table write port, honoured only in IDLE
//     cfg_last, cfg_loop         : last entry index and wrap mode, latched on start
//     start, stop, tick          : run control and accepted-sample strobe
//     dp_areset_n                : reset to the datapath (low only in CLR)
//     phase, phase_valid         : phase-increment interface to the datapath
//     busy, hop_idx              : run status and active entry index
//     hop_strobe, done, cfg_err  : one-cycle event pulses
module freq_hop_sched
  import freq_hop_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DWELL_W    = 32,
  parameter int CLR_CYCLES = 2,
  localparam int IDX_W     = idx_width(DEPTH)
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [IDX_W-1:0]   cfg_last,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  output logic               dp_areset_n,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               busy,
  output logic [IDX_W-1:0]   hop_idx,
  output logic               hop_strobe,
  output logic               done,
  output logic               cfg_err
);

  localparam int CNT_W = $clog2(CLR_CYCLES + 1);

  state_e             state_q;
  logic [CNT_W-1:0]   clr_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [IDX_W-1:0]   hop_idx_q;
  logic [IDX_W-1:0]   last_q;
  logic               loop_q;
  logic               dp_areset_n_q;
  logic [PHASE_W-1:0] phase_q;
  logic               phase_valid_q;
  logic               busy_q;
  logic               hop_strobe_q;
  logic               done_q;
  logic               cfg_err_q;

  logic               tbl_we;
  logic               at_last;
  logic [IDX_W-1:0]   nxt_idx_d;
  logic [PHASE_W-1:0] cur_phase;
  logic [PHASE_W-1:0] nxt_phase;
  logic [DWELL_W-1:0] nxt_dwell;
  logic [DWELL_W-1:0] nxt_dwell_d;

  assign tbl_we  = cfg_we && (state_q == IDLE);
  assign at_last = (hop_idx_q == last_q);

  // The "next" read port always points at the entry that would load on the
  // following hop. Outside RUN that is entry 0, which is what CLR loads.
  assign nxt_idx_d = ((state_q == RUN) && !at_last) ? hop_idx_q + IDX_W'(1) : '0;

  // A programmed dwell of 0 behaves as a dwell of 1 sample.
  assign nxt_dwell_d = (nxt_dwell == '0) ? DWELL_W'(1) : nxt_dwell;

  freq_hop_table #(
    .DEPTH   (DEPTH),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk         (clk),
    .areset_n    (areset_n),
    .we_i        (tbl_we),
    .waddr_i     (cfg_addr),
    .wphase_i    (cfg_phase),
    .wdwell_i    (cfg_dwell),
    .cur_idx_i   (hop_idx_q),
    .cur_phase_o (cur_phase),
    .nxt_idx_i   (nxt_idx_d),
    .nxt_phase_o (nxt_phase),
    .nxt_dwell_o (nxt_dwell)
  );

  // Scheduler FSM with registered outputs. On reset dp_areset_n is driven
  // high so the datapath never sees a spurious reset pulse from us.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      dwell_cnt_q   <= '0;
      hop_idx_q     <= '0;
      last_q        <= '0;
      loop_q        <= 1'b0;
      dp_areset_n_q <= 1'b1;
      phase_q       <= IDLE_PHASE;
      phase_valid_q <= 1'b1;
      busy_q        <= 1'b0;
      hop_strobe_q  <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      hop_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= cfg_we && (state_q != IDLE);

      if (stop && (state_q != IDLE)) begin
        // Abort: back to passthrough with no done pulse.
        state_q       <= IDLE;
        hop_idx_q     <= '0;
        dp_areset_n_q <= 1'b1;
        phase_q       <= IDLE_PHASE;
        phase_valid_q <= 1'b1;
        busy_q        <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // start together with stop is ignored (stop has priority).
            if (start && !stop) begin
              state_q       <= CLR;
              clr_cnt_q     <= CNT_W'(CLR_CYCLES);
              last_q        <= cfg_last;
              loop_q        <= cfg_loop;
              dp_areset_n_q <= 1'b0;
              phase_q       <= IDLE_PHASE;
              phase_valid_q <= 1'b0;
              busy_q        <= 1'b1;
            end
          end

          CLR: begin
            // Leaving on the count-to-zero edge keeps the pulse exactly
            // CLR_CYCLES cycles long.
            if (clr_cnt_q == CNT_W'(1)) begin
              state_q       <= RUN;
              clr_cnt_q     <= '0;
              hop_idx_q     <= '0;
              dwell_cnt_q   <= nxt_dwell_d;
              phase_q       <= nxt_phase;
              dp_areset_n_q <= 1'b1;
              phase_valid_q <= 1'b1;
              hop_strobe_q  <= 1'b1;
            end else begin
              clr_cnt_q <= clr_cnt_q - CNT_W'(1);
            end
          end

          RUN: begin
            phase_q <= cur_phase;
            if (tick) begin
              if (dwell_cnt_q == DWELL_W'(1)) begin
                if (!at_last || loop_q) begin
                  // Next entry loads in the same cycle, so phase has no gap.
                  hop_idx_q    <= nxt_idx_d;
                  dwell_cnt_q  <= nxt_dwell_d;
                  phase_q      <= nxt_phase;
                  hop_strobe_q <= 1'b1;
                end else begin
                  state_q       <= IDLE;
                  hop_idx_q     <= '0;
                  phase_q       <= IDLE_PHASE;
                  phase_valid_q <= 1'b1;
                  busy_q        <= 1'b0;
                  done_q        <= 1'b1;
                end
              end else begin
                dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
              end
            end
          end

          default: begin
            state_q       <= IDLE;
            dp_areset_n_q <= 1'b1;
            phase_q       <= IDLE_PHASE;
            phase_valid_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dp_areset_n = dp_areset_n_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign busy        = busy_q;
  assign hop_idx     = hop_idx_q;
  assign hop_strobe  = hop_strobe_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_freq_hop_sched.sv
// tb_freq_hop_sched
//   Self-checking bench for freq_hop_sched. A behavioural model tracks the
//   run as "mode, active entry, samples consumed in that entry" and the
//   expected outputs are derived from that each cycle; directed sequences
//   add hand-computed expectations on top.
module tb_freq_hop_sched;

  localparam int DEPTH      = 8;
  localparam int DWELL_W    = 32;
  localparam int CLR_CYCLES = 2;
  localparam int IDX_W      = 3;

  logic               clk;
  logic               areset_n;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [15:0]        cfg_phase;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [IDX_W-1:0]   cfg_last;
  logic               cfg_loop;
  logic               start;
  logic               stop;
  logic               tick;
  logic               dp_areset_n;
  logic [15:0]        phase;
  logic               phase_valid;
  logic               busy;
  logic [IDX_W-1:0]   hop_idx;
  logic               hop_strobe;
  logic               done;
  logic               cfg_err;

  int checks = 0;
  int errors = 0;

  freq_hop_sched #(
    .DEPTH      (DEPTH),
    .DWELL_W    (DWELL_W),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_phase   (cfg_phase),
    .cfg_dwell   (cfg_dwell),
    .cfg_last    (cfg_last),
    .cfg_loop    (cfg_loop),
    .start       (start),
    .stop        (stop),
    .tick        (tick),
    .dp_areset_n (dp_areset_n),
    .phase       (phase),
    .phase_valid (phase_valid),
    .busy        (busy),
    .hop_idx     (hop_idx),
    .hop_strobe  (hop_strobe),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: mode 0 = idle, 1 = datapath clear, 2 = running.
  int          mMode  = 0;
  int          mClr   = 0;
  int          mIdx   = 0;
  longint      mUsed  = 0;
  int          mLast  = 0;
  bit          mLoop  = 0;
  bit          eStrobe = 0;
  bit          eDone   = 0;
  bit          eErr    = 0;
  logic [15:0] mPhase [DEPTH] = '{default: '0};
  logic [31:0] mDwell [DEPTH] = '{default: '0};

  function automatic longint effDwell(input logic [31:0] d);
    return (d == 0) ? 1 : longint'(d);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the sequencing rules, advanced on each clock edge.
  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      mMode = 0; mClr = 0; mIdx = 0; mUsed = 0; mLast = 0; mLoop = 0;
      eStrobe = 0; eDone = 0; eErr = 0;
      for (int i = 0; i < DEPTH; i++) begin
        mPhase[i] = '0;
        mDwell[i] = '0;
      end
    end else begin
      eStrobe = 0;
      eDone   = 0;
      eErr    = cfg_we && (mMode != 0);
      if (cfg_we && mMode == 0) begin
        mPhase[cfg_addr] = cfg_phase;
        mDwell[cfg_addr] = cfg_dwell;
      end
      if (stop) begin
        if (mMode != 0) begin
          mMode = 0;
          mIdx  = 0;
        end
      end else if (mMode == 0) begin
        if (start) begin
          mMode = 1;
          mClr  = 0;
          mLast = int'(cfg_last);
          mLoop = cfg_loop;
        end
      end else if (mMode == 1) begin
        mClr++;
        if (mClr == CLR_CYCLES) begin
          mMode = 2; mIdx = 0; mUsed = 0; eStrobe = 1;
        end
      end else if (tick) begin
        mUsed++;
        if (mUsed >= effDwell(mDwell[mIdx])) begin
          mUsed = 0;
          if (mIdx < mLast) begin
            mIdx++; eStrobe = 1;
          end else if (mLoop) begin
            mIdx = 0; eStrobe = 1;
          end else begin
            mMode = 0; mIdx = 0; eDone = 1;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] expPhase;
    logic [31:0] expFlags;
    logic [31:0] actFlags;
    expPhase = (mMode == 2) ? mPhase[mIdx] : 16'h0000;
    expFlags = {26'd0, (mMode != 1), (mMode != 1), (mMode != 0), eStrobe, eDone, eErr};
    actFlags = {26'd0, dp_areset_n, phase_valid, busy, hop_strobe, done, cfg_err};
    checkOutput("modelPhase", 32'(phase), 32'(expPhase));
    checkOutput("modelFlags", actFlags, expFlags);
    checkOutput("modelHopIdx", 32'(hop_idx), 32'(mIdx));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one clock's worth of inputs, then return them to idle.
  task automatic applyStimulus(input logic we, input logic [IDX_W-1:0] addr,
                               input logic [15:0] ph, input logic [31:0] dw,
                               input logic st, input logic sp, input logic tk);
    cfg_we = we; cfg_addr = addr; cfg_phase = ph; cfg_dwell = dw;
    start = st; stop = sp; tick = tk;
    cycle();
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic writeEntry(input logic [IDX_W-1:0] addr, input logic [15:0] ph, input logic [31:0] dw);
    applyStimulus(1'b1, addr, ph, dw, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic startAndWait(input logic [IDX_W-1:0] last, input logic loop);
    int n;
    cfg_last = last;
    cfg_loop = loop;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(busy && dp_areset_n) && n < 10) begin
      cycle();
      n++;
    end
    checkOutput("runEntered", 32'(busy && dp_areset_n), 32'd1);
  endtask

  initial begin
    int lowCnt;
    int strobes;
    int dones;
    int tickCount;
    bit gotDone;
    int idxSeq [10];
    int expSeq [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};

    cfg_we = 0; cfg_addr = '0; cfg_phase = '0; cfg_dwell = '0;
    cfg_last = '0; cfg_loop = 0; start = 0; stop = 0; tick = 0;
    areset_n = 1'b1;
    #2 areset_n = 1'b0;
    #20 areset_n = 1'b1;
    #1;

    // Reset / idle state
    checkOutput("rstPhase", 32'(phase), 32'h0);
    checkOutput("rstValid", 32'(phase_valid), 32'd1);
    checkOutput("rstDpRst", 32'(dp_areset_n), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);

    writeEntry(3'd0, 16'h0100, 32'd3);
    checkOutput("idleWriteErr", 32'(cfg_err), 32'd0);
    writeEntry(3'd1, 16'hFF00, 32'd2);

    // Non-looping two-entry run
    cfg_last = 3'd1;
    cfg_loop = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    lowCnt = 0;
    while (dp_areset_n == 1'b0 && lowCnt < 10) begin
      lowCnt++;
      cycle();
    end
    checkOutput("clrPulseLen", 32'(lowCnt), 32'd2);
    checkOutput("firstPhase", 32'(phase), 32'h0100);
    checkOutput("firstStrobe", 32'(hop_strobe), 32'd1);
    doTicks(3);
    checkOutput("hop1Phase", 32'(phase), 32'hFF00);
    checkOutput("hop1Strobe", 32'(hop_strobe), 32'd1);
    checkOutput("hop1Idx", 32'(hop_idx), 32'd1);
    doTicks(2);
    checkOutput("donePulse", 32'(done), 32'd1);
    checkOutput("donePhase", 32'(phase), 32'h0);
    checkOutput("doneBusy", 32'(busy), 32'd0);
    cycle();
    checkOutput("doneOneCycle", 32'(done), 32'd0);

    // Looping run, 10 ticks
    startAndWait(3'd1, 1'b1);
    strobes = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      idxSeq[i] = int'(hop_idx);
      doTicks(1);
      if (hop_strobe) strobes++;
      if (done) dones++;
    end
    for (int i = 0; i < 10; i++) checkOutput("loopIdxSeq", 32'(idxSeq[i]), 32'(expSeq[i]));
    checkOutput("loopStrobes", 32'(strobes), 32'd4);
    checkOutput("loopNoDone", 32'(dones), 32'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("loopStopBusy", 32'(busy), 32'd0);

    // Gapped ticks, third entry with dwell 0 lasts one tick
    writeEntry(3'd2, 16'h0200, 32'd0);
    startAndWait(3'd2, 1'b0);
    tickCount = 0;
    gotDone = 0;
    for (int i = 0; i < 20 && !gotDone; i++) begin
      repeat ($urandom_range(0, 3)) cycle();
      doTicks(1);
      tickCount++;
      if (done) gotDone = 1;
    end
    checkOutput("gapDone", 32'(gotDone), 32'd1);
    checkOutput("gapTickCount", 32'(tickCount), 32'd6);

    // Write during RUN is rejected
    startAndWait(3'd1, 1'b1);
    writeEntry(3'd0, 16'h7777, 32'd5);
    checkOutput("runWriteErr", 32'(cfg_err), 32'd1);
    cycle();
    checkOutput("runWriteErrPulse", 32'(cfg_err), 32'd0);
    doTicks(3);
    checkOutput("runWrHop1", 32'(phase), 32'hFF00);
    doTicks(2);
    checkOutput("runWrTableKept", 32'(phase), 32'h0100);
    doTicks(1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("stopBusy", 32'(busy), 32'd0);
    checkOutput("stopPhase", 32'(phase), 32'h0);
    checkOutput("stopValid", 32'(phase_valid), 32'd1);
    checkOutput("stopNoDone", 32'(done), 32'd0);

    // start together with stop in IDLE
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("startStopBusy", 32'(busy), 32'd0);
    checkOutput("startStopDp", 32'(dp_areset_n), 32'd1);
    cycle();
    checkOutput("startStopStill", 32'(busy), 32'd0);

    // Async reset in CLR
    cfg_last = 3'd0;
    cfg_loop = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("clrBusy", 32'(busy), 32'd1);
    #2 areset_n = 1'b0;
    #1;
    checkOutput("arstDp", 32'(dp_areset_n), 32'd1);
    checkOutput("arstBusy", 32'(busy), 32'd0);
    checkOutput("arstPhase", 32'(phase), 32'h0);
    checkOutput("arstValid", 32'(phase_valid), 32'd1);
    checkOutput("arstIdx", 32'(hop_idx), 32'd0);
    #2 areset_n = 1'b1;

    // Cleared table: entry 0 is phase 0, one-sample dwell
    startAndWait(3'd0, 1'b0);
    checkOutput("clearedPhase", 32'(phase), 32'h0);
    doTicks(1);
    checkOutput("clearedDone", 32'(done), 32'd1);

    // Restart after rewrite
    writeEntry(3'd0, 16'h0100, 32'd3);
    startAndWait(3'd0, 1'b0);
    checkOutput("restartPhase", 32'(phase), 32'h0100);
    doTicks(3);
    checkOutput("restartDone", 32'(done), 32'd1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
